// File: rtl/bnn_act_packer_if.sv
// Handshake/bus bundle for bnn_act_packer: byte capture side, word drain side and layer status.
// Optional BNN_PACK_POPCNT_EN adds the act_popcount status signal.
interface bnn_act_packer_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                layer_start;
  logic [7:0]          bin_in;
  logic                bin_valid;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [CW-1:0]       fifo_count;
  logic [CNT_W-1:0]    word_count;
  logic                overflow;
  logic                layer_done;
`ifdef BNN_PACK_POPCNT_EN
  logic [CNT_W+4:0]    act_popcount;

  modport master (
    output layer_start, bin_in, bin_valid, flush, out_ready,
    input  out_valid, out_data, fifo_count, word_count, overflow, layer_done, act_popcount
  );
  modport slave (
    input  layer_start, bin_in, bin_valid, flush, out_ready,
    output out_valid, out_data, fifo_count, word_count, overflow, layer_done, act_popcount
  );
`else
  modport master (
    output layer_start, bin_in, bin_valid, flush, out_ready,
    input  out_valid, out_data, fifo_count, word_count, overflow, layer_done
  );
  modport slave (
    input  layer_start, bin_in, bin_valid, flush, out_ready,
    output out_valid, out_data, fifo_count, word_count, overflow, layer_done
  );
`endif
endinterface

// File: rtl/bnn_act_packer.sv
// Packs binarized activation bytes four-per-word into a FWFT FIFO with per-layer control.
// Optional BNN_PACK_POPCNT_EN adds a saturating count of 1 bits captured this layer.
module bnn_act_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  bnn_act_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state_reg;
  logic [1:0]       lane_reg;
  logic [31:0]      partial_reg;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CNT_W-1:0] word_count_reg;
  logic             overflow_reg;
  logic             layer_done_reg;

  logic [31:0]      merged;
  logic             capture, flush_act, push_full, push_flush, push, pop, accept;

  // Partial word with the incoming byte dropped into its lane; higher lanes are still zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = (capture && lane_reg == 2'(gi)) ? bus.bin_in
                                                                : partial_reg[gi*8 +: 8];
  end

  // layer_start wins over any byte or flush presented in the same cycle.
  always_comb begin
    capture    = bus.bin_valid && (state_reg == ACTIVE) && !bus.layer_start;
    flush_act  = bus.flush && (state_reg == ACTIVE) && !bus.layer_start;
    push_full  = capture && (lane_reg == 2'd3);
    push_flush = flush_act && !push_full && ((lane_reg != 2'd0) || capture);
    push       = push_full || push_flush;
    pop        = (count_reg != '0) && bus.out_ready;
    accept     = push && ((count_reg < CW'(FIFO_DEPTH)) || pop);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lane_reg       <= '0;
      partial_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      layer_done_reg <= 1'b0;
    end else begin
      layer_done_reg <= 1'b0;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(accept) - CW'(pop);

      if (bus.layer_start) begin
        lane_reg       <= '0;
        partial_reg    <= '0;
        word_count_reg <= '0;
        overflow_reg   <= 1'b0;
        state_reg      <= ACTIVE;
      end else begin
        if (push) begin
          lane_reg    <= '0;
          partial_reg <= '0;
        end else if (capture) begin
          lane_reg    <= lane_reg + 1'b1;
          partial_reg <= merged;
        end
        if (accept && (word_count_reg != {CNT_W{1'b1}}))
          word_count_reg <= word_count_reg + 1'b1;
        if (push && !accept)
          overflow_reg <= 1'b1;
        case (state_reg)
          ACTIVE:  if (flush_act) state_reg <= DRAIN;
          DRAIN: begin
            // Nothing is pushed outside ACTIVE, so an empty FIFO means drain is complete.
            if (count_reg == '0) begin
              state_reg      <= IDLE;
              layer_done_reg <= 1'b1;
            end
          end
          default: state_reg <= state_reg;
        endcase
      end
    end
  end

  assign bus.out_valid  = (count_reg != '0);
  assign bus.out_data   = (count_reg != '0) ? mem[rd_ptr_reg] : 32'd0;
  assign bus.fifo_count = count_reg;
  assign bus.word_count = word_count_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.layer_done = layer_done_reg;

`ifdef BNN_PACK_POPCNT_EN
  logic [CNT_W+4:0] popcnt_reg;
  logic [CNT_W+5:0] popcnt_sum;

  always_comb begin
    popcnt_sum = {1'b0, popcnt_reg} + (CNT_W+6)'($countones(bus.bin_in));
  end

  always_ff @(posedge clk) begin
    if (rst || bus.layer_start) begin
      popcnt_reg <= '0;
    end else if (capture) begin
      popcnt_reg <= popcnt_sum[CNT_W+5] ? {(CNT_W+5){1'b1}} : popcnt_sum[CNT_W+4:0];
    end
  end

  assign bus.act_popcount = popcnt_reg;
`endif
endmodule

// File: tb/tb_bnn_act_packer.sv
// Directed self-checking bench for bnn_act_packer (FIFO_DEPTH=8, CNT_W=16).
module tb_bnn_act_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  bnn_act_packer_if #(.FIFO_DEPTH(8), .CNT_W(16)) bus ();

  bnn_act_packer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.bin_valid = 1'b1;
    bus.bin_in    = b;
    tick();
    bus.bin_valid = 1'b0;
    bus.bin_in    = 8'h00;
  endtask

  task automatic start_layer();
    bus.layer_start = 1'b1;
    tick();
    bus.layer_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b);
    for (int k = 0; k < 4; k++) send_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    vectors++;
    if (bus.out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data got %h want 00000000", bus.out_data); end
    vectors++;
    if (bus.fifo_count !== 4'd0 || bus.word_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_counts got fifo=%0d words=%0d want 0/0", bus.fifo_count, bus.word_count);
    end
    vectors++;
    if (bus.overflow !== 1'b0 || bus.layer_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got ovf=%0b done=%0b want 0/0", bus.overflow, bus.layer_done);
    end
    $display("test_reset done");
  endtask

  task automatic test_pack_word();
    bus.out_ready = 1'b1;
    start_layer();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pack_early_valid got %0b want 0", bus.out_valid); end
    send_byte(8'h44);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
      miscompares++; $display("FAIL pack_word got v=%0b %h want v=1 44332211", bus.out_valid, bus.out_data);
    end
    vectors++;
    if (bus.word_count !== 16'd1) begin miscompares++; $display("FAIL pack_word_count got %0d want 1", bus.word_count); end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.layer_done !== 1'b0) begin
      miscompares++; $display("FAIL pack_after_pop got v=%0b done=%0b want 0/0", bus.out_valid, bus.layer_done);
    end
    $display("test_pack_word done");
  endtask

  task automatic test_flush_partial();
    int pulses;
    bus.out_ready = 1'b1;
    start_layer();
    send_byte(8'hAA); send_byte(8'hBB);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000BBAA) begin
      miscompares++; $display("FAIL flush_partial_word got v=%0b %h want v=1 0000BBAA", bus.out_valid, bus.out_data);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.layer_done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL flush_partial_done got %0d pulses want 1", pulses); end
    // Back in IDLE: bytes are ignored.
    send_word(8'h77);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.word_count !== 16'd1) begin
      miscompares++; $display("FAIL idle_ignores_bytes got v=%0b words=%0d want 0/1", bus.out_valid, bus.word_count);
    end
    $display("test_flush_partial done");
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    bus.out_ready = 1'b0;
    start_layer();
    for (int i = 0; i < 8; i++) begin
      b = 8'(i + 1);
      send_word(b);
    end
    vectors++;
    if (bus.overflow !== 1'b0 || bus.fifo_count !== 4'd8) begin
      miscompares++; $display("FAIL ovf_at_full got ovf=%0b cnt=%0d want 0/8", bus.overflow, bus.fifo_count);
    end
    send_word(8'h09);
    vectors++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1 || bus.word_count !== 16'd8) begin
      miscompares++; $display("FAIL ovf_state got cnt=%0d ovf=%0b words=%0d want 8/1/8", bus.fifo_count, bus.overflow, bus.word_count);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'(i + 1);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {4{b}}) begin
        miscompares++; $display("FAIL ovf_drain[%0d] got v=%0b %h want v=1 %h", i, bus.out_valid, bus.out_data, {4{b}});
      end
      tick();
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drain_empty got %0b want 0", bus.out_valid); end
    $display("test_overflow done");
  endtask

  task automatic test_full_simul_pop();
    logic [7:0]  b;
    logic [31:0] exp;
    bus.out_ready = 1'b0;
    start_layer();
    for (int i = 0; i < 8; i++) begin
      b = 8'(8'h10 + i);
      send_word(b);
    end
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    bus.out_ready = 1'b1;
    send_byte(8'hC4);
    vectors++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b0 || bus.word_count !== 16'd9) begin
      miscompares++; $display("FAIL simul_pop got cnt=%0d ovf=%0b words=%0d want 8/0/9", bus.fifo_count, bus.overflow, bus.word_count);
    end
    for (int j = 0; j < 8; j++) begin
      b   = 8'(8'h11 + j);
      exp = (j < 7) ? {4{b}} : 32'hC4C3C2C1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
        miscompares++; $display("FAIL simul_drain[%0d] got v=%0b %h want v=1 %h", j, bus.out_valid, bus.out_data, exp);
      end
      tick();
    end
    $display("test_full_simul_pop done");
  endtask

  task automatic test_flush_with_byte();
    int pulses;
    int extra;
    bus.out_ready = 1'b1;
    start_layer();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    bus.flush = 1'b1;
    send_byte(8'h04);
    bus.flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201) begin
      miscompares++; $display("FAIL flush_byte_word got v=%0b %h want v=1 04030201", bus.out_valid, bus.out_data);
    end
    pulses = 0;
    extra  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) extra++;
      if (bus.layer_done === 1'b1) pulses++;
    end
    vectors++;
    if (extra != 0 || bus.word_count !== 16'd1) begin
      miscompares++; $display("FAIL flush_byte_no_pad got extra=%0d words=%0d want 0/1", extra, bus.word_count);
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL flush_byte_done got %0d pulses want 1", pulses); end
    $display("test_flush_with_byte done");
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b0;
    start_layer();
    send_word(8'h21); send_word(8'h22);
    send_byte(8'h31); send_byte(8'h32);
    vectors++;
    if (bus.fifo_count !== 4'd2) begin miscompares++; $display("FAIL rst_mid_pre got cnt=%0d want 2", bus.fifo_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== 4'd0 || bus.overflow !== 1'b0 || bus.out_data !== 32'd0) begin
      miscompares++; $display("FAIL rst_mid got v=%0b cnt=%0d ovf=%0b %h want 0/0/0/00000000",
                              bus.out_valid, bus.fifo_count, bus.overflow, bus.out_data);
    end
    start_layer();
    send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
    vectors++;
    if (bus.fifo_count !== 4'd1 || bus.out_data !== 32'h8D7C6B5A) begin
      miscompares++; $display("FAIL rst_mid_lane got cnt=%0d %h want 1 8D7C6B5A", bus.fifo_count, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    $display("test_rst_mid done");
  endtask

`ifdef BNN_PACK_POPCNT_EN
  task automatic test_popcount();
    start_layer();
    vectors++;
    if (bus.act_popcount !== 21'd0) begin miscompares++; $display("FAIL popcnt_clear got %0d want 0", bus.act_popcount); end
    send_byte(8'hFF); send_byte(8'h0F);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.act_popcount !== 21'd12) begin miscompares++; $display("FAIL popcnt got %0d want 12", bus.act_popcount); end
    for (int i = 0; i < 6; i++) tick();
    $display("test_popcount done");
  endtask
`endif

  initial begin
    bus.layer_start = 1'b0;
    bus.bin_in      = 8'h00;
    bus.bin_valid   = 1'b0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_pack_word();
    test_flush_partial();
    test_overflow();
    test_full_simul_pop();
    test_flush_with_byte();
    test_rst_mid();
`ifdef BNN_PACK_POPCNT_EN
    test_popcount();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bnn_act_packer.md
Name: bnn_act_packer

Overview:
Downstream stage of the BNN core. It captures each 8-bit binarized output byte the core produces and packs four bytes into one 32-bit word, so the word is shaped like the next layer's 4x8 data_in bus. Packed words are buffered in a small first-word-fall-through FIFO and drained with a valid/ready handshake. Per-layer control covers start, flush of partial words, completion signalling and overflow detection.

Parameters:
FIFO_DEPTH, 8, number of 32-bit words buffered; power of 2, minimum 2.
CNT_W, 16, width of the per-layer emitted-word counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
layer_start  input  1  one-cycle pulse; begins a new layer and clears partial word, counters and overflow
bin_in  input  8  binarized activation byte from the core; ignored (may be high-Z) when bin_valid=0
bin_valid  input  1  bin_in is valid this cycle (core write strobe delayed one cycle)
flush  input  1  one-cycle pulse; end of layer, emit any partial word, then drain
out_valid  output  1  FIFO head word available
out_ready  input  1  consumer accepts head word
out_data  output  32  FIFO head word; byte k in bits [8k+7:8k] (k=0 maps to next layer data_in[0])
fifo_count  output  log2(FIFO_DEPTH)+1  words currently held
word_count  output  CNT_W  words pushed this layer (saturating)
overflow  output  1  sticky; a word was dropped because the FIFO was full
layer_done  output  1  one-cycle pulse when drain completes

Behaviour:
- Reset: state IDLE; lane=0; partial word=0; FIFO empty; out_valid=0; out_data=0; fifo_count=0; word_count=0; overflow=0; layer_done=0.
- States: IDLE -> ACTIVE on layer_start. ACTIVE -> DRAIN on flush. DRAIN -> IDLE when the FIFO is empty and no push is pending; layer_done pulses for exactly one cycle on that transition.
- layer_start in any state: lane=0, partial=0, word_count=0, overflow=0, state=ACTIVE. FIFO contents are kept and keep draining.
- Packing (ACTIVE only): on bin_valid, write bin_in into partial lane[lane] and increment lane. When lane==3 the completed word {bin_in, partial[23:0]} is pushed in the same cycle and lane wraps to 0. bin_valid outside ACTIVE is ignored.
- flush with lane!=0: push the partial word with unused upper lanes zero-padded; lane=0.
- flush together with bin_valid: the byte is included first, then the flush rules apply to the result. If that byte completes a word, that word is the only push and no extra padded word is generated.
- flush with lane==0 and no bin_valid: no push.
- Push acceptance: accepted when fifo_count<FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
- Rejected push: the word is dropped, overflow is set (sticky until layer_start or rst), and word_count does not increment.
- word_count increments on each accepted push and saturates at 2^CNT_W-1.
- FIFO: FWFT. out_valid = (fifo_count!=0); out_data = head word, holds 0 when empty. A pop occurs when out_valid && out_ready.
- Push latency: a word pushed at edge N appears on out_data/out_valid after edge N (visible in cycle N+1), even if the FIFO was empty.
- Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- out_data is stable while out_valid=1 and out_ready=0.
- rst mid-operation: all state, FIFO contents and partial data are discarded.

Optional Feature:
BNN_PACK_POPCNT_EN
- Defined: adds output act_popcount (CNT_W+5 bits) = number of 1 bits in all bytes accepted via bin_valid in ACTIVE this layer. Cleared by rst and layer_start; saturating. Flush padding is not counted. Dropped words are still counted, because counting happens at byte capture.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- rst, layer_start, 4 bytes 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data=0x44332211 with out_valid for 1 cycle; word_count=1; layer_done=0.
- layer_start, bytes 0xAA,0xBB then flush -> one word 0x0000BBAA; drain completes and layer_done pulses once; state back to IDLE.
- out_ready=0, push 9 words with FIFO_DEPTH=8 -> fifo_count=8; overflow=1; word_count=8; the first 8 words drain in order once out_ready=1.
- FIFO full, out_ready=1, fourth byte arrives -> push accepted with simultaneous pop; fifo_count stays 8; overflow=0.
- bin_valid with flush on the 4th byte (0x01,0x02,0x03,0x04) -> exactly one word 0x04030201 and no padded word; layer_done after drain.
- rst asserted with 2 words queued and lane=2 -> next cycle out_valid=0, fifo_count=0, overflow=0. With BNN_PACK_POPCNT_EN defined, bytes 0xFF,0x0F then flush -> act_popcount=12.
